ts_frame_sequencer: RTL



---
 rtl/sifh_pkg.sv | 24 ++
 rtl/frame_counter.sv | 81 ++++++++
 rtl/ts_frame_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sifh_pkg.sv
// sifh_pkg: shared definitions for the histogram front end.
//   NP_DEFAULT        - timestamp width (matches the builder's Np)
//   DATA_NUM_DEFAULT  - words emitted per pixel
//   PIXEL_NUM_DEFAULT - pixels per acquisition
//   ACQ_NUM_DEFAULT   - acquisitions per frame
//   NO_PHOTON         - all-ones "no photon" code at the default width
//   seq_state_t       - frame sequencer state encoding
package sifh_pkg;

  localparam int NP_DEFAULT        = 16;
  localparam int DATA_NUM_DEFAULT  = 2;
  localparam int PIXEL_NUM_DEFAULT = 200;
  localparam int ACQ_NUM_DEFAULT   = 33333;

  localparam logic [NP_DEFAULT-1:0] NO_PHOTON = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_PAD  = 2'd2,
    S_DROP = 2'd3
  } seq_state_t;

endpackage

// File: rtl/frame_counter.sv
// frame_counter: cascaded slot / pixel / acquisition counters for the
// frame sequencer.
// Ports:
//   clk, res       - clock, synchronous active-high reset
//   clr_i          - clear all counters
//   slot_adv_i     - advance to the next slot within the pixel
//   pix_adv_i      - end of pixel: slot back to 0, pixel (and possibly
//                    acquisition) advances
//   slot_last_o    - slot is on the pixel's final word
//   pix_wrap_o     - pixel is the acquisition's final pixel
//   frame_end_o    - acquisition is the frame's final one; the frame ends at
//                    the pixel where pix_wrap_o is also high
//   pix_o, acq_o   - current pixel / acquisition index
module frame_counter
  import sifh_pkg::*;
#(
  parameter int DATA_NUM  = DATA_NUM_DEFAULT,
  parameter int PIXEL_NUM = PIXEL_NUM_DEFAULT,
  parameter int ACQ_NUM   = ACQ_NUM_DEFAULT
) (
  input  logic        clk,
  input  logic        res,
  input  logic        clr_i,
  input  logic        slot_adv_i,
  input  logic        pix_adv_i,
  output logic        slot_last_o,
  output logic        pix_wrap_o,
  output logic        frame_end_o,
  output logic [7:0]  pix_o,
  output logic [19:0] acq_o
);

  localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(DATA_NUM - 1);
  localparam logic [7:0]    PIX_LAST  = 8'(PIXEL_NUM - 1);
  localparam logic [19:0]   ACQ_LAST  = 20'(ACQ_NUM - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [7:0]    pix_q, pix_d;
  logic [19:0]   acq_q, acq_d;

  assign slot_last_o = (slot_q == SLOT_LAST);
  assign pix_wrap_o  = (pix_q == PIX_LAST);
  assign frame_end_o = (acq_q == ACQ_LAST);
  assign pix_o       = pix_q;
  assign acq_o       = acq_q;

  always_comb begin
    slot_d = slot_q;
    pix_d  = pix_q;
    acq_d  = acq_q;
    if (clr_i) begin
      slot_d = '0;
      pix_d  = '0;
      acq_d  = '0;
    end else if (pix_adv_i) begin
      slot_d = '0;
      if (pix_wrap_o) begin
        pix_d = '0;
        acq_d = frame_end_o ? 20'd0 : acq_q + 20'd1;
      end else begin
        pix_d = pix_q + 8'd1;
      end
    end else if (slot_adv_i) begin
      slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      slot_q <= '0;
      pix_q  <= '0;
      acq_q  <= '0;
    end else begin
      slot_q <= slot_d;
      pix_q  <= pix_d;
      acq_q  <= acq_d;
    end
  end

endmodule

// File: rtl/ts_frame_sequencer.sv
// ts_frame_sequencer: turns a variable-length per-pixel timestamp stream into
// the fixed DATA_NUM words/pixel, PIXEL_NUM pixels/acq, ACQ_NUM acqs/frame
// write sequence consumed by the histogram builder. Short pixels are padded
// with all-ones, surplus beats are dropped.
// Ports:
//   clk, res                  - clock, synchronous active-high reset
//   start                     - begin a frame (honoured in IDLE only)
//   ts_valid/ts_ready         - upstream handshake
//   ts_data, ts_null, ts_last - beat payload, no-photon flag, end of pixel
//   wrEn, data                - registered builder write strobe and word
//   busy                      - frame in progress
//   frame_done                - pulse on the frame's final word
//   pix_idx, acq_idx          - indices of the current word
// Build option: TS_RESERVED_CLAMP_EN - a real photon whose timestamp is
// all-ones is emitted as all-ones minus 1 so it cannot alias "no photon".
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// FWD   | accepting beats, one word per accepted beat
// PAD   | pixel ended early, emit all-ones until the last slot
// DROP  | pixel full, swallow beats until ts_last
module ts_frame_sequencer
  import sifh_pkg::*;
#(
  parameter int NP        = NP_DEFAULT,
  parameter int DATA_NUM  = DATA_NUM_DEFAULT,
  parameter int PIXEL_NUM = PIXEL_NUM_DEFAULT,
  parameter int ACQ_NUM   = ACQ_NUM_DEFAULT
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          ts_valid,
  output logic          ts_ready,
  input  logic [NP-1:0] ts_data,
  input  logic          ts_null,
  input  logic          ts_last,
  output logic          wrEn,
  output logic [NP-1:0] data,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    pix_idx,
  output logic [19:0]   acq_idx
);

  localparam logic [NP-1:0] NO_PH = '1;

  seq_state_t state_q, state_d;

  logic          wr_en_q, wr_en_d;
  logic [NP-1:0] data_q, data_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    pix_idx_q, pix_idx_d;
  logic [19:0]   acq_idx_q, acq_idx_d;

  logic          clr, slot_adv, pix_adv;
  logic          slot_last, pix_wrap, frame_end, last_pix;
  logic          accept, emit;
  logic [NP-1:0] beat_word, word;
  logic [7:0]    pix_cnt;
  logic [19:0]   acq_cnt;

  frame_counter #(
    .DATA_NUM  (DATA_NUM),
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM)
  ) u_frame_counter (
    .clk         (clk),
    .res         (res),
    .clr_i       (clr),
    .slot_adv_i  (slot_adv),
    .pix_adv_i   (pix_adv),
    .slot_last_o (slot_last),
    .pix_wrap_o  (pix_wrap),
    .frame_end_o (frame_end),
    .pix_o       (pix_cnt),
    .acq_o       (acq_cnt)
  );

  assign ts_ready = (state_q == S_FWD) || (state_q == S_DROP);
  assign accept   = ts_valid && ts_ready;
  assign last_pix = pix_wrap && frame_end;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    beat_word = ts_null ? NO_PH : ts_data;
`ifdef TS_RESERVED_CLAMP_EN
    if (!ts_null && (ts_data == NO_PH)) beat_word = NO_PH - NP'(1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    clr          = 1'b0;
    slot_adv     = 1'b0;
    pix_adv      = 1'b0;
    emit         = 1'b0;
    word         = NO_PH;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (start) state_d = S_FWD;
      end
      S_FWD: begin
        if (accept) begin
          emit = 1'b1;
          word = beat_word;
          if (slot_last) begin
            // Last slot's word is the pixel's final word even if the pixel
            // then continues into DROP, so frame_done goes out with it.
            frame_done_d = last_pix;
            if (ts_last) begin
              pix_adv = 1'b1;
              state_d = last_pix ? S_IDLE : S_FWD;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            slot_adv = 1'b1;
            if (ts_last) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        emit = 1'b1;
        word = NO_PH;
        if (slot_last) begin
          pix_adv      = 1'b1;
          frame_done_d = last_pix;
          state_d      = last_pix ? S_IDLE : S_FWD;
        end else begin
          slot_adv = 1'b1;
        end
      end
      S_DROP: begin
        if (accept && ts_last) begin
          pix_adv = 1'b1;
          state_d = last_pix ? S_IDLE : S_FWD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = emit;
    data_d    = data_q;
    pix_idx_d = pix_idx_q;
    acq_idx_d = acq_idx_q;
    if (emit) begin
      data_d    = word;
      pix_idx_d = pix_cnt;
      acq_idx_d = acq_cnt;
    end else if (state_q == S_IDLE) begin
      pix_idx_d = '0;
      acq_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      wr_en_q      <= 1'b0;
      data_q       <= NO_PH;
      frame_done_q <= 1'b0;
      pix_idx_q    <= '0;
      acq_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      pix_idx_q    <= pix_idx_d;
      acq_idx_q    <= acq_idx_d;
    end
  end

  assign wrEn       = wr_en_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign pix_idx    = pix_idx_q;
  assign acq_idx    = acq_idx_q;

endmodule
